// File: rtl/ysyx_23060059_rd_arbiter.sv
// ---------------------------------------------------------------------------
// ysyx_23060059_rd_arbiter
//
// Two-master, one-slave AXI4 read-channel arbiter. The IFU (master 0) and the
// LSU (master 1) share one memory read port toward the SoC crossbar, and only
// one read may be outstanding at a time. LSU write channels do not pass
// through this block. Burst attributes (arlen/arsize/arburst) are tied off
// outside this module.
//
// Configuration macro:
//   YSYX_23060059_ARB_RR_EN  defined   -> round-robin on simultaneous requests
//                            undefined -> fixed priority, LSU over IFU
//
// Ports:
//   clock, reset        rising-edge clock, asynchronous active-low reset
//   ifu_ar*/ifu_r*      IFU read address / read data channels (master 0)
//   lsu_ar*/lsu_r*      LSU read address / read data channels (master 1)
//   s_ar*               registered request toward the slave; s_arid = grant
//   s_r*                slave read data channel; s_rready follows the grantee
// ---------------------------------------------------------------------------
module ysyx_23060059_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              ifu_arvalid,
  output logic              ifu_arready,
  input  logic [ADDR_W-1:0] ifu_araddr,
  output logic              ifu_rvalid,
  input  logic              ifu_rready,
  output logic [1:0]        ifu_rresp,
  output logic [DATA_W-1:0] ifu_rdata,

  input  logic              lsu_arvalid,
  output logic              lsu_arready,
  input  logic [ADDR_W-1:0] lsu_araddr,
  output logic              lsu_rvalid,
  input  logic              lsu_rready,
  output logic [1:0]        lsu_rresp,
  output logic [DATA_W-1:0] lsu_rdata,

  output logic              s_arvalid,
  input  logic              s_arready,
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  input  logic              s_rvalid,
  output logic              s_rready,
  input  logic [1:0]        s_rresp,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic              s_rlast,
  input  logic [ID_W-1:0]   s_rid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              grant_q, grant_d;
  logic              arvalid_q, arvalid_d;
  logic [ADDR_W-1:0] araddr_q, araddr_d;
  logic              pick;
  logic              rreadySel;

`ifdef YSYX_23060059_ARB_RR_EN
  logic              last_grant_q, last_grant_d;

  // On contention the master that did not win last time goes first; a lone
  // requester always wins regardless of history.
  always_comb begin
    if (ifu_arvalid && lsu_arvalid) pick = ~last_grant_q;
    else                            pick = lsu_arvalid;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_grant_q <= 1'b0;
    else        last_grant_q <= last_grant_d;
  end
`else
  // Fixed priority: whenever the LSU asks it wins, otherwise the IFU does.
  assign pick = lsu_arvalid;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
    end
  end

  // Next-state and output decode. Master-facing handshakes are only ever
  // opened for the grantee, so a master cannot complete an AR handshake
  // before it has been granted, and the loser keeps waiting with arready = 0.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
`ifdef YSYX_23060059_ARB_RR_EN
    last_grant_d = last_grant_q;
`endif
    ifu_arready = 1'b0;
    lsu_arready = 1'b0;
    ifu_rvalid  = 1'b0;
    lsu_rvalid  = 1'b0;
    ifu_rresp   = '0;
    lsu_rresp   = '0;
    ifu_rdata   = '0;
    lsu_rdata   = '0;
    s_rready    = 1'b0;
    rreadySel   = grant_q ? lsu_rready : ifu_rready;

    unique case (state_q)
      IDLE: begin
        if (ifu_arvalid || lsu_arvalid) begin
          grant_d   = pick;
          araddr_d  = pick ? lsu_araddr : ifu_araddr;
          arvalid_d = 1'b1;
          state_d   = ADDR;
`ifdef YSYX_23060059_ARB_RR_EN
          last_grant_d = pick;
`endif
        end
      end

      // The request is committed once latched: dropping arvalid here does
      // not withdraw it.
      ADDR: begin
        if (grant_q) lsu_arready = s_arready;
        else         ifu_arready = s_arready;
        if (s_arready) begin
          arvalid_d = 1'b0;
          state_d   = DATA;
        end
      end

      // Beats are routed by grant, not by s_rid; error responses complete
      // the transaction like any other.
      DATA: begin
        s_rready = rreadySel;
        if (grant_q) begin
          lsu_rvalid = s_rvalid;
          lsu_rresp  = s_rresp;
          lsu_rdata  = s_rdata;
        end else begin
          ifu_rvalid = s_rvalid;
          ifu_rresp  = s_rresp;
          ifu_rdata  = s_rdata;
        end
        if (s_rvalid && rreadySel && s_rlast) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign s_arvalid = arvalid_q;
  assign s_araddr  = araddr_q;
  assign s_arid    = {{(ID_W-1){1'b0}}, grant_q};

  // A response whose ID disagrees with the outstanding request points at a
  // slave or crossbar bug; routing still follows the grant.
  ridMatchesGrant: assert property (@(posedge clock) disable iff (!reset)
    (state_q == DATA && s_rvalid) |-> (s_rid == s_arid));

endmodule

// File: tb/tb_ysyx_23060059_rd_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ysyx_23060059_rd_arbiter
//
// Self-checking bench for the two-master read arbiter. A transaction-level
// model (one optional in-flight read: owner, address, whether its address
// was accepted) predicts every DUT output each cycle; directed scenarios add
// literal expectations on top.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ysyx_23060059_rd_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;
`ifdef YSYX_23060059_ARB_RR_EN
  localparam bit RrEn = 1'b1;
`else
  localparam bit RrEn = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic              ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
  logic [ADDR_W-1:0] ifu_araddr;
  logic [1:0]        ifu_rresp;
  logic [DATA_W-1:0] ifu_rdata;
  logic              lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
  logic [ADDR_W-1:0] lsu_araddr;
  logic [1:0]        lsu_rresp;
  logic [DATA_W-1:0] lsu_rdata;
  logic              s_arvalid, s_arready, s_rvalid, s_rready, s_rlast;
  logic [ADDR_W-1:0] s_araddr;
  logic [ID_W-1:0]   s_arid, s_rid;
  logic [1:0]        s_rresp;
  logic [DATA_W-1:0] s_rdata;

  int checks = 0;
  int errors = 0;

  // Model of the single outstanding read.
  logic              mActive  = 1'b0;
  logic              mArDone  = 1'b0;
  logic              mOwner   = 1'b0;
  logic              mLast    = 1'b0;
  logic [ADDR_W-1:0] mAddr    = '0;

  ysyx_23060059_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clock(clock), .reset(reset),
    .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
    .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp),
    .ifu_rdata(ifu_rdata),
    .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready), .lsu_araddr(lsu_araddr),
    .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready), .lsu_rresp(lsu_rresp),
    .lsu_rdata(lsu_rdata),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
    .s_arid(s_arid), .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rresp(s_rresp),
    .s_rdata(s_rdata), .s_rlast(s_rlast), .s_rid(s_rid)
  );

  // Free-running 10 ns clock.
  always #5 clock = ~clock;

  // The bench's slave always answers with the ID of the request it accepted.
  assign s_rid = {{(ID_W-1){1'b0}}, mOwner};

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Who wins when the bus is free: a lone requester, or on contention the
  // LSU (fixed) / the one that did not win last time (round-robin).
  function automatic logic modelPick(input logic ifuReq, input logic lsuReq,
                                     input logic last);
    if (ifuReq && lsuReq) return RrEn ? ~last : 1'b1;
    return lsuReq;
  endfunction

  // On every falling edge compare all outputs with the model, then advance
  // the model with the inputs that the DUT will sample on the next rising
  // edge. Inputs only change just after rising edges, so they are stable here.
  always @(negedge clock) begin : compareProc
    logic addrPh, dataPh, expRready;
    logic [DATA_W-1:0] ifuData, lsuData;
    if (!reset) begin
      mActive = 1'b0;
      mArDone = 1'b0;
      mOwner  = 1'b0;
      mLast   = 1'b0;
      mAddr   = '0;
    end else begin
      addrPh    = mActive && !mArDone;
      dataPh    = mActive && mArDone;
      expRready = dataPh && (mOwner ? lsu_rready : ifu_rready);
      ifuData   = (dataPh && !mOwner) ? s_rdata : '0;
      lsuData   = (dataPh && mOwner) ? s_rdata : '0;

      checkOutput("s_arvalid", s_arvalid, addrPh);
      checkOutput("s_araddr", s_araddr, mAddr);
      checkOutput("s_arid", s_arid, mOwner);
      checkOutput("ifu_arready", ifu_arready, addrPh && !mOwner && s_arready);
      checkOutput("lsu_arready", lsu_arready, addrPh && mOwner && s_arready);
      checkOutput("s_rready", s_rready, expRready);
      checkOutput("ifu_rvalid", ifu_rvalid, dataPh && !mOwner && s_rvalid);
      checkOutput("lsu_rvalid", lsu_rvalid, dataPh && mOwner && s_rvalid);
      checkOutput("ifu_rdata", ifu_rdata, ifuData);
      checkOutput("lsu_rdata", lsu_rdata, lsuData);
      checkOutput("ifu_rresp", ifu_rresp, (dataPh && !mOwner) ? s_rresp : 2'b00);
      checkOutput("lsu_rresp", lsu_rresp, (dataPh && mOwner) ? s_rresp : 2'b00);

      if (!mActive) begin
        if (ifu_arvalid || lsu_arvalid) begin
          mOwner  = modelPick(ifu_arvalid, lsu_arvalid, mLast);
          mLast   = mOwner;
          mAddr   = mOwner ? lsu_araddr : ifu_araddr;
          mActive = 1'b1;
          mArDone = 1'b0;
        end
      end else if (!mArDone) begin
        if (s_arready) mArDone = 1'b1;
      end else if (s_rvalid && expRready && s_rlast) begin
        mActive = 1'b0;
      end
    end
  end

  task automatic stepCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idleInputs();
    ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b0;
    lsu_arvalid = 1'b0; lsu_araddr = '0; lsu_rready = 1'b0;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rresp = 2'b00;
    s_rdata = '0; s_rlast = 1'b0;
  endtask

  // Accept the pending address, then return one final beat.
  task automatic serveSlave(input logic [63:0] data, input logic [1:0] resp);
    s_arready = 1'b1;
    stepCycle();
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = data; s_rresp = resp; s_rlast = 1'b1;
    ifu_rready = 1'b1; lsu_rready = 1'b1;
    stepCycle();
    s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00; s_rlast = 1'b0;
  endtask

  // One cycle of random master and slave activity.
  task automatic applyStimulus();
    ifu_arvalid = ($urandom_range(3) == 0);
    lsu_arvalid = ($urandom_range(3) == 0);
    ifu_araddr  = $urandom;
    lsu_araddr  = $urandom;
    ifu_rready  = ($urandom_range(3) != 0);
    lsu_rready  = ($urandom_range(3) != 0);
    s_arready   = ($urandom_range(2) == 0);
    s_rvalid    = $urandom_range(1);
    s_rlast     = $urandom_range(1);
    s_rresp     = 2'($urandom_range(3));
    s_rdata     = {$urandom, $urandom};
  endtask

  task automatic testIfuOnly();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
    stepCycle();
    checkOutput("t1 s_arvalid", s_arvalid, 1'b1);
    checkOutput("t1 s_arid", s_arid, 4'd0);
    checkOutput("t1 s_araddr", s_araddr, 32'h8000_0000);
    ifu_arvalid = 1'b0;
    stepCycle();
    checkOutput("t1 s_arvalid held", s_arvalid, 1'b1);
    s_arready = 1'b1;
    #1;
    checkOutput("t1 ifu_arready", ifu_arready, 1'b1);
    checkOutput("t1 lsu_arready", lsu_arready, 1'b0);
    stepCycle();
    s_arready = 1'b0;
    checkOutput("t1 s_arvalid drop", s_arvalid, 1'b0);
    s_rvalid = 1'b1; s_rdata = 64'h1234_5678; s_rresp = 2'b00; s_rlast = 1'b1;
    ifu_rready = 1'b1;
    #1;
    checkOutput("t1 ifu_rvalid", ifu_rvalid, 1'b1);
    checkOutput("t1 ifu_rdata", ifu_rdata, 64'h1234_5678);
    checkOutput("t1 s_rready", s_rready, 1'b1);
    stepCycle();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0; ifu_rready = 1'b0;
    // Back in IDLE: a new request shows up on the slave one cycle later.
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0008;
    stepCycle();
    checkOutput("t1 idle again", s_arvalid, 1'b1);
    checkOutput("t1 second addr", s_araddr, 32'h8000_0008);
    ifu_arvalid = 1'b0;
    serveSlave(64'h1, 2'b00);
  endtask

  task automatic testSimultaneous();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0000;
    lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_03f8;
    stepCycle();
    checkOutput("t2 first arid", s_arid, 4'd1);
    checkOutput("t2 first addr", s_araddr, 32'ha000_03f8);
    lsu_arvalid = 1'b0;
    serveSlave(64'hdead_beef, 2'b00);
    stepCycle();
    checkOutput("t2 second arid", s_arid, 4'd0);
    checkOutput("t2 second addr", s_araddr, 32'h8000_0000);
    ifu_arvalid = 1'b0;
    serveSlave(64'h2, 2'b00);
  endtask

  task automatic testRepeated();
    reset = 1'b0;
    stepCycle();
    reset = 1'b1;
    stepCycle();
    for (int i = 0; i < 4; i++) begin
      ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_1000 + 32'(i);
      lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_2000 + 32'(i);
      stepCycle();
      checkOutput($sformatf("t3 grant%0d", i), s_arid,
                  (RrEn && (i % 2 == 1)) ? 4'd0 : 4'd1);
      ifu_arvalid = 1'b0; lsu_arvalid = 1'b0;
      serveSlave(64'(i), 2'b00);
    end
  endtask

  task automatic testStalledData();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0100;
    stepCycle();
    ifu_arvalid = 1'b0;
    s_arready = 1'b1;
    stepCycle();
    s_arready = 1'b0;
    lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_0010;
    ifu_rready = 1'b0; lsu_rready = 1'b1;
    s_rvalid = 1'b1; s_rlast = 1'b1; s_rdata = 64'h55;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput($sformatf("t4 lsu_arready%0d", i), lsu_arready, 1'b0);
      checkOutput($sformatf("t4 s_rready%0d", i), s_rready, 1'b0);
      stepCycle();
    end
    ifu_rready = 1'b1;
    #1;
    checkOutput("t4 s_rready go", s_rready, 1'b1);
    stepCycle();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
    checkOutput("t4 idle lsu_arready", lsu_arready, 1'b0);
    stepCycle();
    checkOutput("t4 lsu granted", s_arid, 4'd1);
    checkOutput("t4 lsu addr", s_araddr, 32'ha000_0010);
    lsu_arvalid = 1'b0;
    serveSlave(64'h3, 2'b00);
  endtask

  task automatic testErrorResp();
    lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_03f8;
    stepCycle();
    lsu_arvalid = 1'b0;
    s_arready = 1'b1;
    stepCycle();
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rresp = 2'b10; s_rlast = 1'b1; s_rdata = 64'hcafe;
    lsu_rready = 1'b1;
    #1;
    checkOutput("t5 lsu_rresp", lsu_rresp, 2'b10);
    checkOutput("t5 lsu_rvalid", lsu_rvalid, 1'b1);
    stepCycle();
    s_rvalid = 1'b0; s_rresp = 2'b00; s_rlast = 1'b0; s_rdata = '0;
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0200;
    stepCycle();
    checkOutput("t5 next s_arvalid", s_arvalid, 1'b1);
    checkOutput("t5 next arid", s_arid, 4'd0);
    ifu_arvalid = 1'b0;
    serveSlave(64'h4, 2'b00);
  endtask

  task automatic testAsyncReset();
    lsu_arvalid = 1'b1; lsu_araddr = 32'ha000_0400;
    stepCycle();
    lsu_arvalid = 1'b0;
    checkOutput("t6 in ADDR", s_arvalid, 1'b1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("t6 async s_arvalid", s_arvalid, 1'b0);
    checkOutput("t6 async s_araddr", s_araddr, 32'h0);
    checkOutput("t6 async s_arid", s_arid, 4'd0);
    stepCycle();
    stepCycle();
    reset = 1'b1;
    stepCycle();
    ifu_arvalid = 1'b1; ifu_araddr = 32'h8000_0040;
    stepCycle();
    ifu_arvalid = 1'b0;
    checkOutput("t6 new arid", s_arid, 4'd0);
    checkOutput("t6 new addr", s_araddr, 32'h8000_0040);
    s_arready = 1'b1;
    stepCycle();
    s_arready = 1'b0;
    s_rvalid = 1'b1; s_rdata = 64'h7777; s_rlast = 1'b1; ifu_rready = 1'b1;
    #1;
    checkOutput("t6 ifu_rdata", ifu_rdata, 64'h7777);
    stepCycle();
    s_rvalid = 1'b0; s_rlast = 1'b0; s_rdata = '0;
  endtask

  initial begin
    idleInputs();
    ifu_rready = 1'b1; lsu_rready = 1'b1; s_rvalid = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset s_arvalid", s_arvalid, 1'b0);
    checkOutput("reset s_araddr", s_araddr, 32'h0);
    checkOutput("reset s_arid", s_arid, 4'd0);
    checkOutput("reset s_rready", s_rready, 1'b0);
    checkOutput("reset ifu_rvalid", ifu_rvalid, 1'b0);
    checkOutput("reset lsu_rvalid", lsu_rvalid, 1'b0);
    idleInputs();
    reset = 1'b1;
    stepCycle();

    testIfuOnly();
    testSimultaneous();
    testRepeated();
    testStalledData();
    testErrorResp();
    testAsyncReset();

    for (int c = 0; c < 3000; c++) begin
      applyStimulus();
      stepCycle();
    end
    idleInputs();
    stepCycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
